scoreboard_register_file: RTL and testbench

- Parametrised multi-read-port integer register file for the pipelined RISC-V core.
- Combines architectural register storage with a per-register pending-write scoreboard, so decode can detect RAW hazards and stall.
- Sits between decode (reads, issue) and writeback (writes).
- Next generation of the single-cycle register file: configurable width, depth and read-port count; credit-counted scoreboard; optional write-bypass.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/scoreboard_register_file_pending_counter.sv | 47 ++++
 rtl/scoreboard_register_file.sv | 135 +++++++++++++
 tb/tb_scoreboard_register_file.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded integer register file.
// Holds the default data width, register count, stack-pointer index and
// reset value, plus the address/data typedefs used by the default build.
// Optional feature macro used by this slice: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int          DEF_XLEN    = 32;
  localparam int          DEF_NREGS   = 32;
  localparam int          DEF_AW      = $clog2(DEF_NREGS);
  localparam int          DEF_SP_IDX  = 2;
  localparam logic [31:0] DEF_SP_INIT = 32'h0000_2ffc;

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;

endpackage

// File: rtl/scoreboard_register_file_pending_counter.sv
// pending_counter: per-register saturating up/down count of outstanding writes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : an accepted issue targets this register
//   dec        : a writeback targets this register
//   clr        : pipeline squash, wins over inc/dec
//   busy       : count is non-zero
//   full       : count is at its maximum, further issues must stall
//   last       : count is exactly one (only with REGFILE_BYPASS_EN)
// Optional feature macro: REGFILE_BYPASS_EN.
module pending_counter #(
  parameter int PEND_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic busy,
`ifdef REGFILE_BYPASS_EN
  output logic last,
`endif
  output logic full
);

  logic [PEND_W-1:0] r_cnt;

  // Simultaneous inc and dec cancel; neither direction ever wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !dec && !full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (dec && !inc && busy) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign busy = (r_cnt != '0);
  assign full = (r_cnt == '1);
`ifdef REGFILE_BYPASS_EN
  assign last = (r_cnt == PEND_W'(1));
`endif

endmodule

// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file: multi-read-port integer register file with a
// per-register pending-write scoreboard for RAW hazard detection.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   rs_addr / rs_dout   : NUM_RD packed asynchronous read ports
//   rs_busy             : per read port, addressed register has a pending write
//   issue_valid/_rd     : decode allocates a producer; issue_ready = not full
//   wb_valid/_rd/_data  : writeback port (data written on the rising edge)
//   flush               : clears all pending counters, data untouched
//   wb_underflow        : sticky, writeback seen with no pending producer
//   dbg_addr / dbg_dout : asynchronous debug read port
// Register 0 reads as zero, ignores writes and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN (write-first read bypass).
module scoreboard_register_file
  import regfile_pkg::*;
#(
  parameter int               XLEN    = DEF_XLEN,
  parameter int               NREGS   = DEF_NREGS,
  parameter int               AW      = $clog2(NREGS),
  parameter int               NUM_RD  = 2,
  parameter int               PEND_W  = 2,
  parameter int               SP_IDX  = DEF_SP_IDX,
  parameter logic [XLEN-1:0]  SP_INIT = XLEN'(DEF_SP_INIT)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_dout,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  output logic                   issue_ready,
  input  logic                   wb_valid,
  input  logic [AW-1:0]          wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   flush,
  output logic                   wb_underflow,
  input  logic [AW-1:0]          dbg_addr,
  output logic [XLEN-1:0]        dbg_dout
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic             r_underflow;
  logic [NREGS-1:0] w_busy;
  logic [NREGS-1:0] w_full;
  logic             w_iss_acc;
`ifdef REGFILE_BYPASS_EN
  logic [NREGS-1:0] w_last;
`endif

  // Register 0 has no counter: never busy, never full, so issues to it
  // are always accepted and vanish.
  assign w_busy[0] = 1'b0;
  assign w_full[0] = 1'b0;
`ifdef REGFILE_BYPASS_EN
  assign w_last[0] = 1'b0;
`endif

  assign issue_ready = !w_full[issue_rd];
  assign w_iss_acc   = issue_valid && issue_ready;

  for (genvar g = 1; g < NREGS; g++) begin : g_cnt
    logic w_inc;
    logic w_dec;
    assign w_inc = w_iss_acc && (issue_rd == AW'(g));
    assign w_dec = wb_valid  && (wb_rd    == AW'(g));

    pending_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk   (clk),
      .rst_n (reset_n),
      .inc   (w_inc),
      .dec   (w_dec),
      .clr   (flush),
      .busy  (w_busy[g]),
`ifdef REGFILE_BYPASS_EN
      .last  (w_last[g]),
`endif
      .full  (w_full[g])
    );
  end

  // Architectural storage; the stack pointer comes out of reset preloaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wb_valid && (wb_rd != '0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // A writeback racing a flush is an expected squash, not an underflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underflow <= 1'b0;
    end else if (wb_valid && (wb_rd != '0) && !w_busy[wb_rd] && !flush) begin
      r_underflow <= 1'b1;
    end
  end

  assign wb_underflow = r_underflow;

  always_comb begin
    logic [AW-1:0] v_a;
    v_a     = '0;
    rs_dout = '0;
    rs_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      v_a = rs_addr[k*AW +: AW];
      rs_dout[k*XLEN +: XLEN] = (v_a == '0) ? '0 : r_regs[v_a];
      rs_busy[k]              = w_busy[v_a];
`ifdef REGFILE_BYPASS_EN
      // Write-first: forward the writeback, and drop busy when this
      // writeback retires the last producer (unless an issue refills it).
      if (wb_valid && (wb_rd == v_a) && (v_a != '0)) begin
        rs_dout[k*XLEN +: XLEN] = wb_data;
        if (w_last[v_a] && !(w_iss_acc && (issue_rd == v_a))) begin
          rs_busy[k] = 1'b0;
        end
      end
`endif
    end
  end

  always_comb begin
    dbg_dout = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && (wb_rd == dbg_addr) && (dbg_addr != '0)) begin
      dbg_dout = wb_data;
    end
`endif
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
module tb_scoreboard_register_file;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  rs_addr;
  logic [63:0] rs_dout;
  logic [1:0]  rs_busy;
  logic        issue_valid;
  reg_addr_t   issue_rd;
  logic        issue_ready;
  logic        wb_valid;
  reg_addr_t   wb_rd;
  xlen_t       wb_data;
  logic        flush;
  logic        wb_underflow;
  reg_addr_t   dbg_addr;
  xlen_t       dbg_dout;

  int n_checks = 0;
  int n_errors = 0;

  scoreboard_register_file dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rs_addr      (rs_addr),
    .rs_dout      (rs_dout),
    .rs_busy      (rs_busy),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .wb_underflow (wb_underflow),
    .dbg_addr     (dbg_addr),
    .dbg_dout     (dbg_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
    rs_addr = {a1, a0};
    #1;
  endtask

  task automatic idle;
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_issue(input reg_addr_t rd);
    issue_valid = 1'b1; issue_rd = rd;
    tick();
    idle();
  endtask

  task automatic do_wb(input reg_addr_t rd, input xlen_t d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    tick();
    idle();
  endtask

  initial begin
    reset_n = 1'b0; rs_addr = '0; issue_rd = '0; wb_rd = '0; wb_data = '0; dbg_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();

    // Reset state
    set_rd(5'd2, 5'd5);
    dbg_addr = 5'd2; #1;
    check("rst_sp",       rs_dout[31:0],  32'h0000_2ffc);
    check("rst_r5",       rs_dout[63:32], 32'h0);
    check("rst_busy",     {30'b0, rs_busy}, 32'h0);
    check("rst_ready",    {31'b0, issue_ready}, 32'h1);
    check("rst_uflow",    {31'b0, wb_underflow}, 32'h0);
    check("rst_dbg_sp",   dbg_dout, 32'h0000_2ffc);

    // Write then read (with a matching producer so no underflow)
    do_issue(5'd7);
    do_wb(5'd7, 32'hdeadbeef);
    set_rd(5'd7, 5'd0);
    check("wr_r7",        rs_dout[31:0], 32'hdeadbeef);
    check("wr_r7_busy",   {31'b0, rs_busy[0]}, 32'h0);
    do_wb(5'd0, 32'hffffffff);
    #1;
    check("wr_r0",        rs_dout[63:32], 32'h0);
    check("wr_uflow",     {31'b0, wb_underflow}, 32'h0);

    // Scoreboard saturation on rd 9
    set_rd(5'd9, 5'd0);
    for (int i = 0; i < 3; i++) begin
      issue_rd = 5'd9; #1;
      check("sb_ready_pre", {31'b0, issue_ready}, 32'h1);
      do_issue(5'd9);
    end
    issue_rd = 5'd9; issue_valid = 1'b1; #1;
    check("sb_full",      {31'b0, issue_ready}, 32'h0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      check("sb_busy_pre", {31'b0, rs_busy[0]}, 32'h1);
      do_wb(5'd9, 32'h0000_0900 + i);
      issue_rd = 5'd9; #1;
      check("sb_ready_post", {31'b0, issue_ready}, 32'h1);
    end
    check("sb_busy_done", {31'b0, rs_busy[0]}, 32'h0);
    check("sb_data",      rs_dout[31:0], 32'h0000_0902);
    check("sb_uflow",     {31'b0, wb_underflow}, 32'h0);

    // Simultaneous issue and writeback on rd 4 with cnt = 1
    do_issue(5'd4);
    issue_valid = 1'b1; issue_rd = 5'd4;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h0000_a5a5;
    tick();
    idle();
    set_rd(5'd4, 5'd0);
    check("sim_data",     rs_dout[31:0], 32'h0000_a5a5);
    check("sim_busy",     {31'b0, rs_busy[0]}, 32'h1);
    do_wb(5'd4, 32'h0000_a5a6);
    check("sim_busy_end", {31'b0, rs_busy[0]}, 32'h0);
    check("sim_uflow",    {31'b0, wb_underflow}, 32'h0);

    // Underflow on rd 12, sticky
    do_wb(5'd12, 32'h0000_1200);
    set_rd(5'd12, 5'd0);
    check("uf_data",      rs_dout[31:0], 32'h0000_1200);
    check("uf_flag",      {31'b0, wb_underflow}, 32'h1);
    tick(); tick();
    check("uf_sticky",    {31'b0, wb_underflow}, 32'h1);

    // Flush clears pending rd 3 and discards a same-cycle issue
    do_issue(5'd3);
    set_rd(5'd3, 5'd0);
    check("fl_busy_pre",  {31'b0, rs_busy[0]}, 32'h1);
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    idle();
    check("fl_busy_post", {31'b0, rs_busy[0]}, 32'h0);

    // Same-cycle read of a register being written
    do_issue(5'd6);
    do_wb(5'd6, 32'h0000_0055);
    do_issue(5'd6);
    set_rd(5'd0, 5'd6);
    dbg_addr = 5'd6;
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h0000_1234; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_dout",     rs_dout[63:32], 32'h0000_1234);
    check("byp_busy",     {31'b0, rs_busy[1]}, 32'h0);
    check("byp_dbg",      dbg_dout, 32'h0000_1234);
`else
    check("byp_dout",     rs_dout[63:32], 32'h0000_0055);
    check("byp_busy",     {31'b0, rs_busy[1]}, 32'h1);
    check("byp_dbg",      dbg_dout, 32'h0000_0055);
`endif
    tick();
    idle();
    #1;
    check("byp_after",    rs_dout[63:32], 32'h0000_1234);

    // Asynchronous reset mid-operation
    do_issue(5'd9);
    set_rd(5'd9, 5'd7);
    #2 reset_n = 1'b0;
    #1;
    check("ar_busy",      {30'b0, rs_busy}, 32'h0);
    check("ar_r7",        rs_dout[63:32], 32'h0);
    check("ar_uflow",     {31'b0, wb_underflow}, 32'h0);
    set_rd(5'd2, 5'd7);
    check("ar_sp",        rs_dout[31:0], 32'h0000_2ffc);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
